// File: rtl/s27_pkg.sv
// Shared constants and the MISR step function for the s27 scan array.
// The function is also imported by the bench model so both use one definition.
package s27_pkg;

    localparam int STATE_BITS = 3;
    localparam int IDX_G5     = 0;
    localparam int IDX_G6     = 1;
    localparam int IDX_G7     = 2;

    localparam int              SIG_W_DEFAULT = 16;
    localparam int              SIG_W_MAX     = 32;
    localparam logic [15:0]     DEFAULT_POLY  = 16'h002D;
    localparam logic [SIG_W_MAX-1:0] ONE_W    = {{(SIG_W_MAX-1){1'b0}}, 1'b1};

    // Operands are carried at SIG_W_MAX bits; width selects the live low bits.
    function automatic logic [SIG_W_MAX-1:0] misr_next(
        input logic [SIG_W_MAX-1:0] sig,
        input logic [SIG_W_MAX-1:0] data_in,
        input logic [SIG_W_MAX-1:0] poly,
        input int unsigned          width = SIG_W_DEFAULT
    );
        logic [SIG_W_MAX-1:0] mask;
        logic [SIG_W_MAX-1:0] shifted;
        logic                 msb;
        mask    = (width >= SIG_W_MAX) ? '1 : ((ONE_W << width) - ONE_W);
        msb     = |(sig & (ONE_W << (width - 1)));
        shifted = (sig << 1) ^ (msb ? poly : '0);
        return (shifted ^ data_in) & mask;
    endfunction

endpackage

// File: rtl/s27_lane.sv
// One s27 core: combinational next-state/output logic plus three
// mux-scan state flops ordered G5 (head), G6, G7 (tail).
module s27_lane
    import s27_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic se,
    input  logic ce,
    input  logic scan_in,
    input  logic g0,
    input  logic g1,
    input  logic g2,
    input  logic g3,
    output logic g17,
    output logic scan_out
);

    logic [STATE_BITS-1:0] state;
    logic g5, g6, g7;
    logic g8, g9, g10, g11, g12, g13, g14, g15, g16;

    assign g5 = state[IDX_G5];
    assign g6 = state[IDX_G6];
    assign g7 = state[IDX_G7];

    always_comb begin
        g14 = ~g0;
        g12 = ~(g1 | g7);
        g13 = ~(g2 | g12);
        g8  = g14 & g6;
        g15 = g12 | g8;
        g16 = g3 | g8;
        g9  = ~(g16 & g15);
        g11 = ~(g5 | g9);
        g10 = ~(g14 | g11);
        g17 = ~g11;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
        end else if (se) begin
            // Scan shift: scan_in -> G5 -> G6 -> G7 -> scan_out
            state[IDX_G5] <= scan_in;
            state[IDX_G6] <= state[IDX_G5];
            state[IDX_G7] <= state[IDX_G6];
        end else if (ce) begin
            state[IDX_G5] <= g10;
            state[IDX_G6] <= g11;
            state[IDX_G7] <= g13;
        end
    end

    assign scan_out = state[IDX_G7];

endmodule

// File: rtl/s27_scan_array.sv
// LANES s27 cores on a single scan chain, with a MISR compacting the G17 bus
// on every capture edge.
module s27_scan_array
    import s27_pkg::*;
#(
    parameter int               LANES = 4,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             SE,
    input  logic             SI,
    input  logic             CE,
    input  logic [LANES-1:0] G0,
    input  logic [LANES-1:0] G1,
    input  logic [LANES-1:0] G2,
    input  logic [LANES-1:0] G3,
    output logic [LANES-1:0] G17,
    output logic             SO,
    output logic [SIG_W-1:0] SIG
);

    logic [LANES:0] chain;

    assign chain[0] = SI;
    assign SO       = chain[LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        s27_lane u_lane (
            .clk      (CK),
            .rst      (RST),
            .se       (SE),
            .ce       (CE),
            .scan_in  (chain[i]),
            .g0       (G0[i]),
            .g1       (G1[i]),
            .g2       (G2[i]),
            .g3       (G3[i]),
            .g17      (G17[i]),
            .scan_out (chain[i+1])
        );
    end

    logic [SIG_W_MAX-1:0] sig_ext;
    logic [SIG_W_MAX-1:0] g17_ext;
    logic [SIG_W_MAX-1:0] poly_ext;
    logic [SIG_W_MAX-1:0] sig_wide;
    logic [SIG_W-1:0]     sig_next;

    always_comb begin
        sig_ext                = '0;
        sig_ext[SIG_W-1:0]     = SIG;
        g17_ext                = '0;
        g17_ext[LANES-1:0]     = G17;
        poly_ext               = '0;
        poly_ext[SIG_W-1:0]    = POLY;
        sig_wide               = misr_next(sig_ext, g17_ext, poly_ext, SIG_W);
        sig_next               = sig_wide[SIG_W-1:0];
    end

    // Bits above SIG_W are always zero from misr_next; fold them away.
    if (SIG_W < SIG_W_MAX) begin : g_hi
        logic unused_hi;
        assign unused_hi = |sig_wide[SIG_W_MAX-1:SIG_W];
    end

    // Scan mode freezes the signature so shifting does not disturb it.
    always_ff @(posedge CK) begin
        if (RST) begin
            SIG <= '0;
        end else if (SE) begin
            SIG <= SIG;
        end else if (CE) begin
            SIG <= sig_next;
        end
    end

endmodule

// File: tb/tb_s27_scan_array.sv
// Scoreboard bench for s27_scan_array: stimulus pushes expected observations,
// a monitor pops and compares them just before each rising edge.
module tb_s27_scan_array;
    import s27_pkg::*;

    localparam int LANES = 4;
    localparam int SIG_W = 16;

    logic             CK = 1'b0;
    logic             RST = 1'b1, SE = 1'b0, SI = 1'b0, CE = 1'b0;
    logic [LANES-1:0] G0 = '0, G1 = '0, G2 = '0, G3 = '0;
    logic [LANES-1:0] G17;
    logic             SO;
    logic [SIG_W-1:0] SIG;

    s27_scan_array #(.LANES(LANES), .SIG_W(SIG_W), .POLY(16'h002D)) dut (
        .CK(CK), .RST(RST), .SE(SE), .SI(SI), .CE(CE),
        .G0(G0), .G1(G1), .G2(G2), .G3(G3),
        .G17(G17), .SO(SO), .SIG(SIG)
    );

    always #5 CK = ~CK;

    localparam int K_G17 = 0;
    localparam int K_SO  = 1;
    localparam int K_SIG = 2;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] val;
    } exp_t;

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string cur = "init";

    logic [11:0] m_chain = '0;
    logic [15:0] m_sig   = '0;
    bit          m_ok    = 1'b0;

    // Returns {g10, g11, g13, g17}
    function automatic logic [3:0] lane_f(input logic g0, g1, g2, g3, g5, g6, g7);
        logic g8, g9, g10, g11, g12, g13, g14, g15, g16;
        g14 = ~g0;
        g12 = ~(g1 | g7);
        g13 = ~(g2 | g12);
        g8  = g14 & g6;
        g15 = g12 | g8;
        g16 = g3 | g8;
        g9  = ~(g16 & g15);
        g11 = ~(g5 | g9);
        g10 = ~(g14 | g11);
        return {g10, g11, g13, ~g11};
    endfunction

    task automatic hand(input string nm, input int kind, input logic [15:0] v);
        exp_t e;
        e.name = nm;
        e.kind = kind;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic step(input logic rst, input logic se, input logic si, input logic ce,
                        input logic [3:0] a0, input logic [3:0] a1,
                        input logic [3:0] a2, input logic [3:0] a3);
        logic [3:0]  g17e;
        logic [11:0] nxt;
        logic [3:0]  r;
        @(negedge CK);
        RST = rst; SE = se; SI = si; CE = ce;
        G0 = a0; G1 = a1; G2 = a2; G3 = a3;
        for (int i = 0; i < LANES; i++) begin
            r = lane_f(a0[i], a1[i], a2[i], a3[i],
                       m_chain[3*i], m_chain[3*i+1], m_chain[3*i+2]);
            g17e[i]    = r[0];
            nxt[3*i]   = r[3];
            nxt[3*i+1] = r[2];
            nxt[3*i+2] = r[1];
        end
        if (m_ok) begin
            hand({cur, "/model_g17"}, K_G17, {12'h000, g17e});
            hand({cur, "/model_so"},  K_SO,  {15'h0000, m_chain[11]});
            hand({cur, "/model_sig"}, K_SIG, m_sig);
        end
        if (rst) begin
            m_chain = '0;
            m_sig   = '0;
            m_ok    = 1'b1;
        end else if (se) begin
            m_chain = {m_chain[10:0], si};
        end else if (ce) begin
            m_sig   = 16'(misr_next({16'h0000, m_sig}, {28'h0, g17e}, 32'h0000_002D));
            m_chain = nxt;
        end
    endtask

    // Monitor: samples 2 time units before each rising edge
    initial begin
        exp_t        e;
        logic [15:0] act;
        forever begin
            @(negedge CK);
            #3;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.kind)
                    K_G17:   act = {12'h000, G17};
                    K_SO:    act = {15'h0000, SO};
                    default: act = SIG;
                endcase
                n_cmp++;
                if (act !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic [15:0] hold_sig;
        logic [11:0] seq;
        seq = 12'b1011_0010_1101;

        // Reset and post-reset G17 = G1 | ~G3
        cur = "t1";
        step(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'hF);
        step(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'hF);
        hand("t1_g17_g3hi", K_G17, 16'h0000);
        hand("t1_sig", K_SIG, 16'h0000);
        hand("t1_so", K_SO, 16'h0000);
        #1;
        n_cmp++;
        if (G17 !== 4'h0) begin
            n_bad++;
            $display("FAIL t1_direct_g17: got %h expected 0", G17);
        end
        n_cmp++;
        if (SIG !== 16'h0000) begin
            n_bad++;
            $display("FAIL t1_direct_sig: got %h expected 0000", SIG);
        end
        n_cmp++;
        if (SO !== 1'b0) begin
            n_bad++;
            $display("FAIL t1_direct_so: got %b expected 0", SO);
        end
        step(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        hand("t1_g17_g3lo", K_G17, 16'h000F);
        step(1, 0, 0, 0, 4'h0, 4'h5, 4'h0, 4'hF);
        hand("t1_g17_mix", K_G17, 16'h0005);

        // Functional capture from 000 -> 010, then 010 holds under same inputs
        cur = "t2";
        step(0, 0, 0, 1, 4'hF, 4'h0, 4'h0, 4'hF);
        hand("t2_g17_a", K_G17, 16'h0000);
        step(0, 0, 0, 1, 4'hF, 4'h0, 4'h0, 4'hF);
        hand("t2_g17_b", K_G17, 16'h0000);
        step(0, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'hF);
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 0, 0, 4'hF, 4'h0, 4'h0, 4'hF);
            hand($sformatf("t2_unload%0d", k), K_SO, (k % 3 == 1) ? 16'h0001 : 16'h0000);
        end

        // Full chain fill with ones, then flush with zeros
        cur = "t3";
        step(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int k = 1; k <= 24; k++) begin
            step(0, 1, (k <= 12), 0, 4'h0, 4'h0, 4'h0, 4'h0);
            hand($sformatf("t3_so%0d", k), K_SO, (k >= 13) ? 16'h0001 : 16'h0000);
        end
        step(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        hand("t3_so_end", K_SO, 16'h0000);

        // MISR: first capture with G17 = F, then random captures
        cur = "t4";
        step(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        step(0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
        hand("t4_g17", K_G17, 16'h000F);
        step(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        hand("t4_sig_first", K_SIG, 16'h000F);
        #1;
        n_cmp++;
        if (SIG !== 16'h000F) begin
            n_bad++;
            $display("FAIL t4_direct_sig: got %h expected 000f", SIG);
        end
        for (int k = 0; k < 200; k++) begin
            step(0, 0, 0, 1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        // Hold: state and SIG frozen while inputs toggle
        cur = "t5";
        step(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        hold_sig = m_sig;
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            hand($sformatf("t5_sig_hold%0d", k), K_SIG, hold_sig);
        end
        #1;
        n_cmp++;
        if (SIG !== hold_sig) begin
            n_bad++;
            $display("FAIL t5_direct_sig: got %h expected %h", SIG, hold_sig);
        end
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        end

        // Reset in the middle of a scan load, then reload a new pattern
        cur = "t6";
        for (int k = 1; k <= 5; k++) begin
            step(0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        end
        step(1, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int k = 0; k < 12; k++) begin
            step(0, 1, seq[k], 0, 4'h0, 4'h0, 4'h0, 4'h0);
            if (k == 0) begin
                hand("t6_sig_rst", K_SIG, 16'h0000);
                hand("t6_so_rst", K_SO, 16'h0000);
            end
        end
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
            hand($sformatf("t6_unload%0d", k), K_SO, {15'h0000, seq[k]});
        end

        @(negedge CK);
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
